fetch_stage: RTL

- Instruction-fetch stage of the 5-stage ARM pipeline.
- Owns the program counter, drives the address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register.
- Handles hazard freeze, branch redirect and flush.
- Keeps a saturating count of instructions delivered to decode, used for CPI measurement in lab runs.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage ARM pipeline.
//
// Owns the program counter, presents it to the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
// Handles hazard freeze, branch redirect and IF/ID flush, and keeps a
// saturating count of instructions handed to decode.
//
// Ports:
//   clk             system clock, all state changes on the rising edge
//   rst             synchronous active-high reset, overrides all other inputs
//   freeze          hazard stall: hold PC and IF/ID
//   branch_taken    branch resolved taken in EX: redirect PC, flush IF/ID
//   branch_addr     branch target from EX (low two bits ignored)
//   flush           flush IF/ID only, no effect on the PC
//   instruction_in  memory word for pc_out, valid in the same cycle
//   pc_out          current PC (the PC register itself)
//   if_pc           PC+4 of the instruction held in IF/ID
//   if_instruction  instruction word held in IF/ID
//   if_valid        IF/ID holds a real instruction
//   fetch_count     saturating count of instructions accepted into IF/ID
module fetch_stage #(
    parameter int unsigned     N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [N-1:0]     branch_addr,
    input  logic             flush,
    input  logic [N-1:0]     instruction_in,
    output logic [N-1:0]     pc_out,
    output logic [N-1:0]     if_pc,
    output logic [N-1:0]     if_instruction,
    output logic             if_valid,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [N-1:0] PcStep    = N'(4);
    localparam logic [N-1:0] AlignMask = ~(N'(3));

    logic [N-1:0]     pc_q, pc_d;
    logic [N-1:0]     if_pc_q, if_pc_d;
    logic [N-1:0]     if_instr_q, if_instr_d;
    logic             if_valid_q, if_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0] pc_plus4;
    logic         accept;

    // Wraps modulo 2^N by construction.
    assign pc_plus4 = pc_q + PcStep;

    // IF/ID loads a fresh instruction only when neither discarding nor stalled.
    assign accept = !(branch_taken || flush) && !freeze;

    // PC next state: branch beats freeze; the target is forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_addr & AlignMask;
        end else if (!freeze) begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID next state: a branch or flush discards even a stalled instruction,
    // since it sits on the wrong path.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        if (branch_taken || flush) begin
            if_pc_d    = '0;
            if_instr_d = '0;
            if_valid_d = 1'b0;
        end else if (!freeze) begin
            if_pc_d    = pc_plus4;
            if_instr_d = instruction_in;
            if_valid_d = 1'b1;
        end
    end

    // Counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_out         = pc_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = if_instr_q;
    assign if_valid       = if_valid_q;
    assign fetch_count    = cnt_q;

endmodule
